// File: rtl/tlp_rx_hdr_parser.sv
// RX TLP header parser: pops DWs from a show-ahead FIFO, presents the 3DW/4DW header
// on a valid/ready port, then streams payload (and optionally the ECRC digest) on a second port.
module tlp_rx_hdr_parser #(
   parameter bit STRIP_ECRC = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fifo_empty_i,
   input  logic [31:0] fifo_rdata_i,
   output logic        fifo_rden_o,
   output logic        hdr_valid_o,
   input  logic        hdr_ready_i,
   output logic [31:0] hdr_dw0_o,
   output logic [31:0] hdr_dw1_o,
   output logic [31:0] hdr_dw2_o,
   output logic [31:0] hdr_dw3_o,
   output logic        hdr_4dw_o,
   output logic        hdr_has_data_o,
   output logic [10:0] hdr_len_dw_o,
   output logic        pld_valid_o,
   input  logic        pld_ready_i,
   output logic [31:0] pld_data_o,
   output logic        pld_last_o,
   output logic        err_o
);

   typedef enum logic [1:0] {S_HDR, S_HOUT, S_PLD, S_ECRC} state_t;

   state_t      state, state_nxt;
   logic [1:0]  hdr_idx;
   logic [10:0] pld_cnt;
   logic [10:0] pld_cnt_load;
   logic        td;
   logic        is_prefix;
   logic        last_hdr_dw;

   assign td             = hdr_dw0_o[15];
   assign hdr_4dw_o      = hdr_dw0_o[29];
   assign hdr_has_data_o = hdr_dw0_o[30];
   // A zero length field encodes 1024 DWs; the MSB is set exactly in that case.
   assign hdr_len_dw_o   = hdr_has_data_o ? {~|hdr_dw0_o[9:0], hdr_dw0_o[9:0]} : 11'd0;
   assign pld_cnt_load   = hdr_has_data_o ? hdr_len_dw_o + {10'd0, td & ~STRIP_ECRC} : 11'd1;

   assign is_prefix   = (hdr_idx == 2'd0) && fifo_rdata_i[31];
   assign last_hdr_dw = (hdr_idx == 2'd3) || ((hdr_idx == 2'd2) && !hdr_4dw_o);

   assign hdr_valid_o = (state == S_HOUT);
   assign pld_data_o  = fifo_rdata_i;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_HDR;
      else        state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      fifo_rden_o = 1'b0;
      pld_valid_o = 1'b0;
      pld_last_o  = 1'b0;
      unique case (state)
         S_HDR: begin
            fifo_rden_o = ~fifo_empty_i;
            if (fifo_rden_o && !is_prefix && last_hdr_dw) state_nxt = S_HOUT;
         end
         S_HOUT: begin
            if (hdr_ready_i) begin
               if (hdr_has_data_o || (td && !STRIP_ECRC)) state_nxt = S_PLD;
               else if (td)                               state_nxt = S_ECRC;
               else                                       state_nxt = S_HDR;
            end
         end
         S_PLD: begin
            pld_valid_o = ~fifo_empty_i;
            fifo_rden_o = pld_valid_o & pld_ready_i;
            pld_last_o  = pld_valid_o & (pld_cnt == 11'd1);
            if (fifo_rden_o && (pld_cnt == 11'd1))
               state_nxt = (td && STRIP_ECRC) ? S_ECRC : S_HDR;
         end
         S_ECRC: begin
            fifo_rden_o = ~fifo_empty_i;
            if (fifo_rden_o) state_nxt = S_HDR;
         end
         default: state_nxt = S_HDR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hdr_idx   <= 2'd0;
         pld_cnt   <= 11'd0;
         hdr_dw0_o <= 32'd0;
         hdr_dw1_o <= 32'd0;
         hdr_dw2_o <= 32'd0;
         hdr_dw3_o <= 32'd0;
         err_o     <= 1'b0;
      end else begin
         err_o <= 1'b0;
         if ((state == S_HDR) && fifo_rden_o) begin
            if (is_prefix) begin
               err_o <= 1'b1;
            end else begin
               unique case (hdr_idx)
                  2'd0: begin
                     hdr_dw0_o <= fifo_rdata_i;
                     hdr_dw3_o <= 32'd0;
                  end
                  2'd1: hdr_dw1_o <= fifo_rdata_i;
                  2'd2: hdr_dw2_o <= fifo_rdata_i;
                  2'd3: hdr_dw3_o <= fifo_rdata_i;
                  default: ;
               endcase
               hdr_idx <= last_hdr_dw ? 2'd0 : hdr_idx + 2'd1;
            end
         end
         if ((state == S_HOUT) && hdr_ready_i) pld_cnt <= pld_cnt_load;
         if ((state == S_PLD) && fifo_rden_o)  pld_cnt <= pld_cnt - 11'd1;
      end
   end

endmodule
